display_capture: RTL and testbench

//  Receiving end of the multiplexed 7-segment display bus (an/dec_cat) that the display driver produces.

---
 rtl/display_capture_pkg.sv | 63 ++++++
 rtl/display_capture_if.sv | 32 +++
 rtl/display_capture_seg_decoder.sv | 32 +++
 rtl/display_capture.sv | 217 +++++++++++++++++++++
 tb/tb_display_capture.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/display_capture_pkg.sv
// Shared constants for the 7-segment display capture: glyph table, dec_cat bit positions, FSM states.
// Optional error counter is enabled by DISP_CAP_ERR_CNT_EN (see display_capture_if / display_capture).
package display_capture_pkg;

  // Active-low {a,b,c,d,e,f,g} segment patterns
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int CAT_DP_BIT  = 0;
  localparam int CAT_SEG_LSB = 1;
  localparam int CAT_SEG_MSB = 7;

  typedef enum logic [1:0] {
    DC_IDLE     = 2'd0,
    DC_SETTLE   = 2'd1,
    DC_CAPTURED = 2'd2
  } dc_state_t;

  typedef enum logic [1:0] {
    AN_BLANK = 2'd0,
    AN_DIGIT = 2'd1,
    AN_MULTI = 2'd2
  } an_class_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/display_capture_if.sv
// Display bus (an/dec_cat) plus the reconstructed digit state reported by the capture block.
// err_cnt exists only when DISP_CAP_ERR_CNT_EN is defined.
interface display_capture_if;
  logic [7:0]  an;
  logic [7:0]  dec_cat;
  logic [31:0] digit_val;
  logic [7:0]  digit_on;
  logic [7:0]  digit_dp;
  logic        frame_done;
  logic        pattern_err;
  logic        multi_an_err;
  logic        locked;
`ifdef DISP_CAP_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  modport master (
    output an, dec_cat,
    input  digit_val, digit_on, digit_dp, frame_done, pattern_err, multi_an_err, locked
`ifdef DISP_CAP_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  an, dec_cat,
    output digit_val, digit_on, digit_dp, frame_done, pattern_err, multi_an_err, locked
`ifdef DISP_CAP_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/display_capture_seg_decoder.sv
// Combinational 7-segment glyph decoder: active-low {a..g} -> {valid, blank, hex value}.
// Reusable wherever a captured segment pattern has to be turned back into a nibble.
module display_capture_seg_decoder
  import display_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] val
);

  logic [15:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_glyph
      assign match[gi] = (seg == seg_glyph(4'(gi)));
    end
  endgenerate

  // Glyphs are unique, so at most one match bit is set
  always_comb begin
    val = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) val = 4'(i);
    end
  end

  assign valid = |match;
  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/display_capture.sv
// Rebuilds 8 digit values / blank / dp flags from a scanned 7-segment bus, flags bad scans, reports lock.
// Define DISP_CAP_ERR_CNT_EN to add the saturating err_cnt output.
module display_capture
  import display_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic            clock,
  input  logic            reset,
  display_capture_if.slave bus
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_FRAMES);

  logic [7:0]       an_reg, cat_reg, an_prev_reg, cat_prev_reg;
  dc_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       visited_reg, visited_next;
  logic [3:0]       frame_cnt_reg, frame_cnt_next;
  logic             frame_done_reg, frame_done_next;
  logic             pattern_err_reg, multi_err_reg;

  an_class_t  an_class;
  logic [2:0] an_idx;
  logic       all_changed, an_changed;
  logic       sample_en, multi_hit, pattern_hit, err_hit;
  logic [7:0] mask_set;
  logic       dec_valid, dec_blank;
  logic [3:0] dec_val;

  // Input registers; the "previous" copy lets us see changes on the registered bus.
  // Reset loads the idle (all-off) bus level so reset release is not seen as a multi-anode event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_reg       <= 8'hFF;
      cat_reg      <= 8'hFF;
      an_prev_reg  <= 8'hFF;
      cat_prev_reg <= 8'hFF;
    end else begin
      an_reg       <= bus.an;
      cat_reg      <= bus.dec_cat;
      an_prev_reg  <= an_reg;
      cat_prev_reg <= cat_reg;
    end
  end

  always_comb begin
    an_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_reg[i]) an_idx = 3'(i);
    end
    if (an_reg == 8'hFF)        an_class = AN_BLANK;
    else if ($onehot(~an_reg))  an_class = AN_DIGIT;
    else                        an_class = AN_MULTI;
  end

  assign all_changed = ({an_reg, cat_reg} != {an_prev_reg, cat_prev_reg});
  assign an_changed  = (an_reg != an_prev_reg);

  display_capture_seg_decoder u_dec (
    .seg   (cat_reg[CAT_SEG_MSB:CAT_SEG_LSB]),
    .valid (dec_valid),
    .blank (dec_blank),
    .val   (dec_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= DC_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sample_en  = 1'b0;
    multi_hit  = 1'b0;
    case (state_reg)
      DC_IDLE: begin
        // A held multi-anode pattern reports once, on the cycle it appears
        if (an_class == AN_DIGIT) begin
          state_next = DC_SETTLE;
          cnt_next   = '0;
        end else if (an_class == AN_MULTI && an_changed) begin
          multi_hit = 1'b1;
        end
      end
      DC_SETTLE: begin
        if (all_changed) begin
          cnt_next = '0;
          if (an_class == AN_BLANK) begin
            state_next = DC_IDLE;
          end else if (an_class == AN_MULTI) begin
            multi_hit  = 1'b1;
            state_next = DC_IDLE;
          end
        end else if (cnt_reg == CNT_LAST) begin
          sample_en  = 1'b1;
          state_next = DC_CAPTURED;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DC_CAPTURED: begin
        if (an_changed) begin
          cnt_next = '0;
          if (an_class == AN_DIGIT) begin
            state_next = DC_SETTLE;
          end else if (an_class == AN_MULTI) begin
            multi_hit  = 1'b1;
            state_next = DC_IDLE;
          end else begin
            state_next = DC_IDLE;
          end
        end
      end
      default: begin
        state_next = DC_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign pattern_hit = sample_en && !dec_valid && !dec_blank;
  assign err_hit     = pattern_hit || multi_hit;
  assign mask_set    = visited_reg | (sample_en ? (8'b1 << an_idx) : 8'h00);

  // Errors take priority over frame completion in the same cycle
  always_comb begin
    visited_next    = mask_set;
    frame_cnt_next  = frame_cnt_reg;
    frame_done_next = 1'b0;
    if (err_hit) begin
      visited_next   = 8'h00;
      frame_cnt_next = 4'd0;
    end else if (mask_set == 8'hFF) begin
      visited_next    = 8'h00;
      frame_done_next = 1'b1;
      if (frame_cnt_reg != LOCK_MAX) frame_cnt_next = frame_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      visited_reg     <= 8'h00;
      frame_cnt_reg   <= 4'd0;
      frame_done_reg  <= 1'b0;
      pattern_err_reg <= 1'b0;
      multi_err_reg   <= 1'b0;
    end else begin
      visited_reg     <= visited_next;
      frame_cnt_reg   <= frame_cnt_next;
      frame_done_reg  <= frame_done_next;
      pattern_err_reg <= pattern_hit;
      multi_err_reg   <= multi_hit;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] val_reg;
      logic       on_reg;
      logic       dp_reg;
      logic       hit;

      assign hit = sample_en && (an_idx == 3'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          val_reg <= 4'h0;
          on_reg  <= 1'b0;
          dp_reg  <= 1'b0;
        end else if (hit) begin
          dp_reg <= ~cat_reg[CAT_DP_BIT];
          if (dec_blank) begin
            on_reg <= 1'b0;
          end else if (dec_valid) begin
            on_reg  <= 1'b1;
            val_reg <= dec_val;
          end
        end
      end

      assign bus.digit_val[gi*4 +: 4] = val_reg;
      assign bus.digit_on[gi]         = on_reg;
      assign bus.digit_dp[gi]         = dp_reg;
    end
  endgenerate

`ifdef DISP_CAP_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt_reg <= 8'h00;
    end else if (err_hit && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`endif

  assign bus.frame_done   = frame_done_reg;
  assign bus.pattern_err  = pattern_err_reg;
  assign bus.multi_an_err = multi_err_reg;
  assign bus.locked       = (frame_cnt_reg == LOCK_MAX);

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: scans, settle filtering, multi-anode/pattern errors, blank digits, reset.
// err_cnt checks run only when DISP_CAP_ERR_CNT_EN is defined.
module tb_display_capture;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   frames_seen = 0;
  int   pattern_seen = 0;
  int   multi_seen = 0;
  int   base;

  display_capture_if bus ();

  display_capture #(.SETTLE_CYCLES(4), .LOCK_FRAMES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.frame_done   === 1'b1) frames_seen++;
    if (bus.pattern_err  === 1'b1) pattern_seen++;
    if (bus.multi_an_err === 1'b1) multi_seen++;
  end

  // Hand-written active-low {a..g} glyphs for digits 0..9
  logic [6:0] glyph [10];
  initial begin
    glyph[0] = 7'b0000001; glyph[1] = 7'b1001111; glyph[2] = 7'b0010010;
    glyph[3] = 7'b0000110; glyph[4] = 7'b1001100; glyph[5] = 7'b0100100;
    glyph[6] = 7'b0100000; glyph[7] = 7'b0001111; glyph[8] = 7'b0000000;
    glyph[9] = 7'b0000100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
    bus.an      = a;
    bus.dec_cat = c;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic show(input int k, input logic [7:0] c);
    logic [7:0] a;
    a = ~(8'b1 << k);
    drive(a, c, 8);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_val"},   bus.digit_val,    32'h0);
    check({tag, "_on"},    {24'h0, bus.digit_on}, 32'h0);
    check({tag, "_dp"},    {24'h0, bus.digit_dp}, 32'h0);
    check({tag, "_fd"},    {31'h0, bus.frame_done},   32'h0);
    check({tag, "_perr"},  {31'h0, bus.pattern_err},  32'h0);
    check({tag, "_merr"},  {31'h0, bus.multi_an_err}, 32'h0);
    check({tag, "_lock"},  {31'h0, bus.locked},       32'h0);
`ifdef DISP_CAP_ERR_CNT_EN
    check({tag, "_ecnt"},  {24'h0, bus.err_cnt},      32'h0);
`endif
  endtask

  initial begin
    bus.an      = 8'hFF;
    bus.dec_cat = 8'hFF;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    drive(8'hFF, 8'hFF, 2);

    // Two clean scans of 0..7
    base = frames_seen;
    for (int k = 0; k < 8; k++) show(k, {glyph[k], 1'b1});
    check("scan1_frames", 32'(frames_seen - base), 32'd1);
    check("scan1_val",    bus.digit_val, 32'h76543210);
    check("scan1_on",     {24'h0, bus.digit_on}, 32'hFF);
    check("scan1_lock",   {31'h0, bus.locked}, 32'h0);
    for (int k = 0; k < 8; k++) show(k, {glyph[k], 1'b1});
    check("scan2_frames", 32'(frames_seen - base), 32'd2);
    check("scan2_lock",   {31'h0, bus.locked}, 32'h1);
    check("scan2_dp",     {24'h0, bus.digit_dp}, 32'h0);

    // Unsettled digit 0: cat toggles every 3 cycles, never sampled
    drive(8'hFF, 8'hFF, 3);
    base = frames_seen;
    for (int i = 0; i < 10; i++) drive(8'hFE, (i % 2 == 0) ? {glyph[8], 1'b1} : {glyph[9], 1'b1}, 3);
    drive(8'hFF, 8'hFF, 3);
    check("toggle_val", bus.digit_val, 32'h76543210);
    check("toggle_on",  {24'h0, bus.digit_on}, 32'hFF);
    // Digits 1..7 alone must not complete a frame if digit 0 was never marked
    for (int k = 1; k < 8; k++) show(k, {glyph[k], 1'b1});
    check("toggle_frames", 32'(frames_seen - base), 32'd0);
    check("toggle_lock",   {31'h0, bus.locked}, 32'h1);

    // Two anodes low, held
    base = multi_seen;
    drive(8'hFC, {glyph[8], 1'b1}, 10);
    check("multi_pulses", 32'(multi_seen - base), 32'd1);
    check("multi_lock",   {31'h0, bus.locked}, 32'h0);
    check("multi_val",    bus.digit_val, 32'h76543210);

    // Digit 3 with g-only pattern and dp lit
    base = pattern_seen;
    show(3, {7'b1111110, 1'b0});
    check("pat_pulses", 32'(pattern_seen - base), 32'd1);
    check("pat_val3",   {28'h0, bus.digit_val[15:12]}, 32'h3);
    check("pat_dp",     {24'h0, bus.digit_dp}, 32'h08);
    check("pat_on",     {24'h0, bus.digit_on}, 32'hFF);

    // Digit 5 blank inside two full scans
    base = frames_seen;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++) show(k, (k == 5) ? 8'hFF : {glyph[k], 1'b1});
    check("blank_frames", 32'(frames_seen - base), 32'd2);
    check("blank_on",     {24'h0, bus.digit_on}, 32'hDF);
    check("blank_val",    bus.digit_val, 32'h76543210);
    check("blank_dp",     {24'h0, bus.digit_dp}, 32'h0);
    check("blank_lock",   {31'h0, bus.locked}, 32'h1);

    // Bad glyph on the digit that would complete the frame: error wins
    base = frames_seen;
    for (int k = 0; k < 7; k++) show(k, {glyph[k], 1'b1});
    show(7, 8'hFD);
    check("errfrm_frames", 32'(frames_seen - base), 32'd0);
    check("errfrm_lock",   {31'h0, bus.locked}, 32'h0);
    check("errfrm_val7",   {28'h0, bus.digit_val[31:28]}, 32'h7);
    for (int k = 0; k < 8; k++) show(k, {glyph[k], 1'b1});
    check("errfrm_after",  32'(frames_seen - base), 32'd1);
    check("errfrm_lock1",  {31'h0, bus.locked}, 32'h0);

    // Reset in the middle of settling digit 2
    drive(8'hFB, {glyph[9], 1'b1}, 3);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    drive(8'hFF, 8'hFF, 2);
    reset = 1'b0;
    drive(8'hFF, 8'hFF, 10);
    check_zero("postreset");

`ifdef DISP_CAP_ERR_CNT_EN
    for (int i = 0; i < 10; i++) begin
      drive(8'hFC, 8'hFF, 1);
      drive(8'hFF, 8'hFF, 1);
    end
    drive(8'hFF, 8'hFF, 2);
    check("ecnt_10", {24'h0, bus.err_cnt}, 32'd10);
    for (int i = 0; i < 290; i++) begin
      drive(8'hFC, 8'hFF, 1);
      drive(8'hFF, 8'hFF, 1);
    end
    drive(8'hFF, 8'hFF, 2);
    check("ecnt_sat", {24'h0, bus.err_cnt}, 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
